// File: rtl/sample_capture_buffer.sv
// Triggered ADC sample capture into a simple dual-port buffer with a registered read port.
// Capture length is latched on arm; a length of 0 selects the full buffer depth.
module sample_capture_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic [ADDR_W-1:0] capture_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count
);

  // state     | meaning
  // S_IDLE    | inactive, buffer and count held
  // S_ARMED   | waiting for trigger, samples ignored
  // S_CAPTURE | writing each valid sample
  // S_DONE    | latched length reached, buffer and count held
  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   len_q;
  logic              arm_ok, wr_en, last_wr;
  logic              busy_nxt, done_nxt;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // The triggering cycle itself may carry the first sample.
  always_comb begin
    arm_ok  = !abort && arm && (state == S_IDLE || state == S_DONE);
    wr_en   = !abort && sample_valid &&
              ((state == S_ARMED && trigger) || state == S_CAPTURE);
    last_wr = wr_en && ((sample_count + (ADDR_W+1)'(1)) == len_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm) state_nxt = S_ARMED;
        S_ARMED: begin
          if (last_wr)      state_nxt = S_DONE;
          else if (trigger) state_nxt = S_CAPTURE;
        end
        S_CAPTURE: if (last_wr) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Decoded from the next state so the registered flags track state exactly.
  always_comb begin
    busy_nxt = (state_nxt == S_ARMED) || (state_nxt == S_CAPTURE);
    done_nxt = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_count <= '0;
      wr_ptr       <= '0;
      len_q        <= FULL_LEN;
    end else if (arm_ok) begin
      sample_count <= '0;
      wr_ptr       <= '0;
      len_q        <= (capture_len == '0) ? FULL_LEN : {1'b0, capture_len};
    end else if (wr_en) begin
      sample_count <= sample_count + (ADDR_W+1)'(1);
      wr_ptr       <= wr_ptr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample_data;
  end

  // Read-before-write on address collision: the old word is returned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_sample_capture_buffer.sv
// Self-checking bench for sample_capture_buffer: read expectations come from a
// bench-side buffer model and flow through a scoreboard queue to the 1-cycle read port.
module tb_sample_capture_buffer;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              arm, abort, trigger, sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [ADDR_W-1:0] capture_len, rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy, done;
  logic [ADDR_W:0]   sample_count;

  int n_vec = 0;
  int n_err = 0;
  logic [DATA_W-1:0] model_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_rd;

  sample_capture_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .arm(arm), .abort(abort), .trigger(trigger),
    .sample_valid(sample_valid), .sample_data(sample_data), .capture_len(capture_len),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; arm = 0; abort = 0; trigger = 0; sample_valid = 0;
    sample_data = '0; capture_len = '0; rd_addr = '0;
    #12;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_vec++; if (sample_count !== 13'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", sample_count); end
    n_vec++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 0000", rd_data); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    capture_len = 12'd8; arm = 1; tick(); arm = 0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_armed_busy: got %b expected 1", busy); end
    trigger = 1;
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1; sample_data = 16'h100 + 16'(i); tick();
      model_mem[i] = 16'h100 + 16'(i);
    end
    sample_valid = 0; trigger = 0;
    n_vec++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done: got done=%b busy=%b expected done=1 busy=0", done, busy); end
    n_vec++; if (sample_count !== 13'd8) begin n_err++; $display("FAIL basic_count: got %0d expected 8", sample_count); end
    sample_valid = 1; trigger = 1; sample_data = 16'hDEAD; tick(); sample_valid = 0; trigger = 0;
    n_vec++; if (sample_count !== 13'd8 || done !== 1'b1) begin n_err++; $display("FAIL basic_done_hold: got count=%0d done=%b expected 8/1", sample_count, done); end
    for (int a = 0; a < 9; a++) begin
      rd_addr = ADDR_W'(a); exp_q.push_back(a < 8 ? model_mem[a] : 16'bx); tick();
      exp_rd = exp_q.pop_front();
      if (a < 8) begin
        n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL basic_read[%0d]: got %h expected %h", a, rd_data, exp_rd); end
      end
    end
  endtask

  task automatic test_full_depth();
    capture_len = '0; arm = 1; tick(); arm = 0; trigger = 1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      sample_valid = 1; sample_data = 16'(i * 7 + 3); tick();
      if (i < DEPTH) model_mem[i] = 16'(i * 7 + 3);
      if (i == DEPTH - 2) begin
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL full_early_done: got %b expected 0", done); end
      end
      if (i == DEPTH - 1) begin
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done_edge: got %b expected 1", done); end
      end
    end
    sample_valid = 0; trigger = 0;
    n_vec++; if (sample_count !== 13'd4096) begin n_err++; $display("FAIL full_count: got %0d expected 4096", sample_count); end
    rd_addr = '0; exp_q.push_back(model_mem[0]); tick(); exp_rd = exp_q.pop_front();
    n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL full_addr0: got %h expected %h", rd_data, exp_rd); end
    rd_addr = 12'd4095; exp_q.push_back(model_mem[4095]); tick(); exp_rd = exp_q.pop_front();
    n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL full_addr4095: got %h expected %h", rd_data, exp_rd); end
  endtask

  task automatic test_pretrigger();
    capture_len = 12'd4; arm = 1; tick(); arm = 0; trigger = 0;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; sample_data = 16'h5500 + 16'(i); tick();
    end
    n_vec++; if (sample_count !== 13'd0 || busy !== 1'b1) begin n_err++; $display("FAIL pretrig_ignored: got count=%0d busy=%b expected 0/1", sample_count, busy); end
    trigger = 1; sample_data = 16'hAAAA; tick(); model_mem[0] = 16'hAAAA; trigger = 0;
    n_vec++; if (sample_count !== 13'd1) begin n_err++; $display("FAIL pretrig_first: got %0d expected 1", sample_count); end
    for (int i = 1; i < 4; i++) begin
      sample_data = 16'hB000 + 16'(i); tick(); model_mem[i] = 16'hB000 + 16'(i);
    end
    sample_valid = 0;
    n_vec++; if (sample_count !== 13'd4 || done !== 1'b1) begin n_err++; $display("FAIL pretrig_done: got count=%0d done=%b expected 4/1", sample_count, done); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = ADDR_W'(a); exp_q.push_back(model_mem[a]); tick(); exp_rd = exp_q.pop_front();
      n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL pretrig_read[%0d]: got %h expected %h", a, rd_data, exp_rd); end
    end
  endtask

  task automatic test_abort();
    capture_len = 12'd16; arm = 1; tick(); arm = 0; trigger = 1;
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1; sample_data = 16'hC000 + 16'(i); tick(); model_mem[i] = 16'hC000 + 16'(i);
    end
    abort = 1; arm = 1; sample_data = 16'hFFFF; tick(); abort = 0; arm = 0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL abort_state: got busy=%b done=%b expected 0/0", busy, done); end
    n_vec++; if (sample_count !== 13'd5) begin n_err++; $display("FAIL abort_count: got %0d expected 5", sample_count); end
    sample_data = 16'hFFFE; tick(); sample_valid = 0; trigger = 0;
    n_vec++; if (sample_count !== 13'd5 || busy !== 1'b0) begin n_err++; $display("FAIL abort_idle_hold: got count=%0d busy=%b expected 5/0", sample_count, busy); end
    for (int a = 4; a < 7; a++) begin
      rd_addr = ADDR_W'(a); exp_q.push_back(model_mem[a]); tick(); exp_rd = exp_q.pop_front();
      n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL abort_read[%0d]: got %h expected %h", a, rd_data, exp_rd); end
    end
  endtask

  task automatic test_rearm();
    capture_len = 12'd4; arm = 1; tick(); arm = 0; trigger = 1;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1; sample_data = 16'h7000 + 16'(i);
      if (i == 2) begin arm = 1; capture_len = 12'd10; end
      tick(); arm = 0; trigger = 0; model_mem[i] = 16'h7000 + 16'(i);
      if (i == 2) begin
        n_vec++; if (sample_count !== 13'd3 || busy !== 1'b1) begin n_err++; $display("FAIL rearm_ignored: got count=%0d busy=%b expected 3/1", sample_count, busy); end
      end
    end
    sample_valid = 0;
    n_vec++; if (sample_count !== 13'd4 || done !== 1'b1) begin n_err++; $display("FAIL rearm_first_done: got count=%0d done=%b expected 4/1", sample_count, done); end
    capture_len = 12'd2; arm = 1; tick(); arm = 0;
    n_vec++; if (done !== 1'b0 || busy !== 1'b1 || sample_count !== 13'd0) begin n_err++; $display("FAIL rearm_from_done: got done=%b busy=%b count=%0d expected 0/1/0", done, busy, sample_count); end
    trigger = 1;
    for (int i = 0; i < 2; i++) begin
      sample_valid = 1; sample_data = 16'h8800 + 16'(i); tick(); model_mem[i] = 16'h8800 + 16'(i);
    end
    sample_valid = 0; trigger = 0;
    n_vec++; if (done !== 1'b1 || sample_count !== 13'd2) begin n_err++; $display("FAIL rearm_new_len: got done=%b count=%0d expected 1/2", done, sample_count); end
    for (int a = 0; a < 4; a++) begin
      rd_addr = ADDR_W'(a); exp_q.push_back(model_mem[a]); tick(); exp_rd = exp_q.pop_front();
      n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL rearm_read[%0d]: got %h expected %h", a, rd_data, exp_rd); end
    end
  endtask

  task automatic test_async_reset();
    capture_len = 12'd20; arm = 1; tick(); arm = 0; trigger = 1;
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1; sample_data = 16'hD000 + 16'(i); tick(); model_mem[i] = 16'hD000 + 16'(i);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL async_flags: got busy=%b done=%b expected 0/0", busy, done); end
    n_vec++; if (sample_count !== 13'd0) begin n_err++; $display("FAIL async_count: got %0d expected 0", sample_count); end
    n_vec++; if (rd_data !== 16'h0) begin n_err++; $display("FAIL async_rd_data: got %h expected 0000", rd_data); end
    tick(); reset_n = 1'b1;
    sample_data = 16'hEEEE;
    for (int i = 0; i < 3; i++) tick();
    sample_valid = 0; trigger = 0;
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== 13'd0) begin n_err++; $display("FAIL async_post_idle: got busy=%b done=%b count=%0d expected 0/0/0", busy, done, sample_count); end
    for (int a = 0; a < 2; a++) begin
      rd_addr = ADDR_W'(a); exp_q.push_back(model_mem[a]); tick(); exp_rd = exp_q.pop_front();
      n_vec++; if (rd_data !== exp_rd) begin n_err++; $display("FAIL async_read[%0d]: got %h expected %h", a, rd_data, exp_rd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_pretrigger();
    test_abort();
    test_rearm();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
